// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB requester types: FSM state encoding and bus widths
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Read data is only meaningful for an error-free read; everything else reports zero.
  function automatic logic [APB_DATA_W-1:0] rsp_data_sel(
    input logic                  write,
    input logic                  slverr,
    input logic [APB_DATA_W-1:0] prdata
  );
    return (!write && !slverr) ? prdata : '0;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - consecutive wait-cycle counter; expired flags the LIMIT-th enabled cycle
module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the FSM leaves ACCESS on the same edge the limit is reached.
  assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - command-to-APB requester (IDLE/SETUP/ACCESS FSM)
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [APB_DATA_W-1:0] PRDATA
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state_q;
  apb_state_e state_d;
  logic       cmd_accept;
  logic       xfer_done;
  logic       timeout_hit;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign xfer_done  = (state_q == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  logic to_clear;
  logic to_enable;
  logic to_expired;

  assign to_clear  = (state_q == SETUP);
  assign to_enable = (state_q == ACCESS) && !PREADY;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  // to_enable already excludes PREADY, so a completing cycle can never also time out.
  assign timeout_hit = to_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   PSEL      = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Address phase signals only change on acceptance, so they hold through the transfer and after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (cmd_accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= xfer_done || timeout_hit;
      if (xfer_done) begin
        rsp_rdata <= rsp_data_sel(PWRITE, PSLVERR, PRDATA);
        rsp_err   <= PSLVERR;
      end else if (timeout_hit) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_timeout <= 1'b0;
    end else if (xfer_done) begin
      rsp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of ACCESS cycles without PREADY before abort (used only when APB_MASTER_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  transfer address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-010 SHALL have port rsp_rdata  output  32  read data; 0 for writes, errors and timeouts.
REQ-011 SHALL have port rsp_err  output  1  PSLVERR seen or timeout.
REQ-012 SHALL have port rsp_timeout  output  1  transfer aborted by timeout.
REQ-013 SHALL have ports PSEL, PENABLE, PWRITE  output  1 each; PADDR, PWDATA  output  32 each  APB requester signals.
REQ-014 SHALL have ports PREADY, PSLVERR  input  1 each; PRDATA  input  32  APB completer signals.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE: cmd_ready = 1, PSEL = 0, PENABLE = 0; handshake registers cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, next state SETUP.
REQ-017 SETUP: PSEL = 1, PENABLE = 0, cmd_ready = 0; unconditionally next state ACCESS.
REQ-018 ACCESS: PSEL = 1, PENABLE = 1; stay while PREADY = 0; on PREADY = 1 next state IDLE.
REQ-019 PWRITE, PADDR, PWDATA SHALL be stable from SETUP through the completing ACCESS cycle and hold last values in IDLE.
REQ-020 On the ACCESS cycle with PREADY = 1, next cycle SHALL assert rsp_valid = 1 for exactly one cycle with rsp_err = PSLVERR, rsp_timeout = 0, rsp_rdata = PRDATA for a read with PSLVERR = 0, else 0.
REQ-021 Zero-wait latency: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3; each PREADY wait cycle adds one.
REQ-022 cmd_ready SHALL be 0 in SETUP and ACCESS; cmd_valid is ignored there; the response cycle is IDLE, so a new command may be accepted concurrently with rsp_valid (back-to-back period 3 cycles).
REQ-023 rsp_rdata, rsp_err, rsp_timeout SHALL hold their values between rsp_valid pulses.
REQ-024 PRDATA and PSLVERR SHALL be sampled only in ACCESS with PREADY = 1.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0, timeout counter = 0.
REQ-026 Reset mid-transfer SHALL abandon the transfer with no rsp_valid; cmd_ready = 1 in the first cycle after release.

Configuration
REQ-027 Macro APB_MASTER_TIMEOUT_EN defined: counter clears on SETUP entry, increments each ACCESS cycle with PREADY = 0; at TIMEOUT_CYCLES consecutive such cycles next state IDLE, PSEL/PENABLE deasserted, next-cycle rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
REQ-028 PREADY = 1 on the same cycle as counter reaching limit SHALL complete normally (PREADY has priority).
REQ-029 Macro undefined: no counter logic, ACCESS waits indefinitely, rsp_timeout tied 0.

Structure
REQ-030 Shared package apb_pkg SHALL hold the FSM state encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2) and APB address/data width constants (32).
REQ-031 Timeout counter SHALL be sub-module apb_timeout_cnt (clear, enable, expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-032 Write addr 0x03, wdata 0xA5, zero-wait completer -> PSEL cycle 1, PENABLE cycle 2, rsp_valid cycle 3, rsp_err = 0, rsp_rdata = 0.
REQ-033 Read addr 0x05, completer PREADY after 3 wait cycles, PRDATA 0x0000003C -> rsp_valid cycle 6, rsp_rdata 0x3C, PADDR stable cycles 1-5.
REQ-034 Read addr 0x10, completer PREADY = 1 with PSLVERR = 1 -> rsp_err = 1, rsp_rdata = 0.
REQ-035 cmd_valid held high for two commands -> second accepted on first rsp_valid cycle, second SETUP one cycle later.
REQ-036 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4, PREADY stuck 0 -> PSEL drops after 4 ACCESS cycles, rsp_timeout = 1, rsp_err = 1.
REQ-037 rst_n asserted during ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid, cmd_ready = 1 after release.
